fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the MIPS pipeline. It owns the program counter, drives the byte address into the combinational `InstructionMemory` and captures the returned word into the IF/ID pipeline register for the decode stage. It supports stalls from the hazard unit, redirects for taken branches and jumps from the execute stage, and an explicit flush. It sits directly upstream of `InstructionMemory` and directly upstream of decode.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0028, byte address loaded on reset (word index 10); bits [1:0] must be 0.
- `NOP_WORD`, 32'h0000_0000, instruction word inserted on bubble or flush.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `stall`  in  1  hold PC and IF/ID contents.
- `flush`  in  1  invalidate the IF/ID contents next cycle.
- `branch_taken`  in  1  load `branch_target` into the PC.
- `branch_target`  in  32  byte address computed in EX.
- `jump`  in  1  load the pseudo-direct jump target into the PC.
- `jump_index`  in  26  instruction[25:0] of the jump.
- `imem_instruction`  in  32  word returned by `InstructionMemory`.
- `imem_address`  out  32  byte address to `InstructionMemory`; equals PC.
- `ifid_instruction`  out  32  instruction held for decode.
- `ifid_pc_plus4`  out  32  PC+4 of the held instruction.
- `ifid_valid`  out  1  held instruction is real (0 = bubble).
- `misaligned`  out  1  sticky flag: a redirect target had bits [1:0] ≠ 0.
- `fetch_count`  out  32  number of instructions accepted into IF/ID.

## Operation
- FSM with two states:
  - HOLD: entered on reset; stays exactly one cycle, then RUN. In HOLD the PC is held at `RESET_PC` and nothing is captured into IF/ID.
  - RUN: normal fetch.
- Next-PC priority, highest first: reset → `RESET_PC`; HOLD → hold; `branch_taken` → `{branch_target[31:2],2'b00}`; `jump` → `{pc_plus4[31:28], jump_index, 2'b00}`; `stall` → hold; otherwise PC+4.
  - `pc_plus4` is the current PC+4.
  - Arithmetic is modulo 2^32: PC 32'hFFFF_FFFC wraps to 0.
- Branch and jump asserted together: branch wins.
- Redirect (branch or jump) overrides `stall`. The IF/ID register is loaded with a bubble: instruction = `NOP_WORD`, valid = 0.
- IF/ID update, priority highest first:
  - reset, or HOLD: bubble, `ifid_pc_plus4` = 0.
  - redirect or `flush`: bubble.
  - `stall`: hold all IF/ID fields.
  - otherwise: capture `imem_instruction`, PC+4, valid = 1.
- `flush` with `stall`: flush wins in IF/ID; the PC still holds unless a redirect is present.
- `misaligned` sets when a taken redirect has `branch_target[1:0] ≠ 0`. It clears only on reset.
- `fetch_count` increments by 1 on every edge that captures with valid = 1. It wraps at 2^32 and resets to 0.

## Timing
- Reset values: PC = `RESET_PC`, `imem_address` = `RESET_PC`, `ifid_instruction` = `NOP_WORD`, `ifid_pc_plus4` = 0, `ifid_valid` = 0, `misaligned` = 0, `fetch_count` = 0, state = HOLD.
- `imem_address` is driven directly from the PC register. `InstructionMemory` is combinational, so the word appears the same cycle.
- Fetch latency is 1 cycle: the word at PC during cycle n appears on `ifid_instruction` in cycle n+1.
- The first valid IF/ID entry appears 2 cycles after `reset` deasserts (one HOLD cycle plus one fetch cycle).
- Redirect penalty is 1 bubble. The target address is presented in the cycle after `branch_taken` or `jump`; its word is valid one cycle later.
- Reset asserted mid-operation takes effect on the next edge regardless of other inputs. Any in-flight IF/ID entry is discarded.

## Structure
- Shared package `mips_pkg` holds:
  - `RESET_PC` default and `NOP_WORD`.
  - the `fetch_state_t` enum {HOLD, RUN}.
  - the width constants: word = 32, jump index = 26.
- One sub-module, `ifid_register`. It holds instruction, pc_plus4 and valid, with ports load, bubble and hold. `fetch_stage` owns the PC, the FSM, the counter and the next-PC mux.

## Test plan
- Reset, then release with the memory returning 32'h0149_4824 at 0x28: `imem_address` = 0x28 during HOLD and the first RUN cycle. In the following cycle, `ifid_instruction` = 32'h0149_4824, `ifid_pc_plus4` = 0x2C, `ifid_valid` = 1, `fetch_count` = 1.
- Sequential run of 4 cycles from 0x28: addresses 0x28, 0x2C, 0x30, 0x34; `fetch_count` = 4.
- `stall` for 2 cycles at PC 0x30: `imem_address` stays 0x30; the IF/ID fields are unchanged; `fetch_count` does not increment.
- `branch_taken` with target 0x78 while `stall` = 1: the next `imem_address` = 0x78; `ifid_valid` = 0 for one cycle; then the word from 0x78 with pc_plus4 0x7C.
- `jump` with `jump_index` = 26'h000_0010 from PC 0x34: the next PC = 0x40. Branch and jump together with branch target 0x100: PC = 0x100.
- Branch target 0x7A: PC = 0x78 and `misaligned` = 1, held across later cycles. Reset asserted mid-stream: all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath widths, fetch defaults and the
// fetch-stage state encoding.
package mips_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned JIDX_W = 26;

    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0028;
    localparam logic [WORD_W-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_ifid_register.sv
// IF/ID pipeline register: instruction, its PC+4 and a valid bit.
// A bubble overrides hold; hold overrides load.
module ifid_register
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic              i_bubble,
    input  logic              i_hold,
    input  logic [WORD_W-1:0] i_instruction,
    input  logic [WORD_W-1:0] i_pc_plus4,
    output logic [WORD_W-1:0] o_instruction,
    output logic [WORD_W-1:0] o_pc_plus4,
    output logic              o_valid
);

    logic [WORD_W-1:0] r_instruction;
    logic [WORD_W-1:0] r_pc_plus4;
    logic              r_valid;

    always_ff @(posedge clk) begin
        if (i_reset || i_bubble) begin
            r_instruction <= NOP_WORD;
            r_pc_plus4    <= '0;
            r_valid       <= 1'b0;
        end else if (i_hold) begin
            r_instruction <= r_instruction;
            r_pc_plus4    <= r_pc_plus4;
            r_valid       <= r_valid;
        end else if (i_load) begin
            r_instruction <= i_instruction;
            r_pc_plus4    <= i_pc_plus4;
            r_valid       <= 1'b1;
        end
    end

    assign o_instruction = r_instruction;
    assign o_pc_plus4    = r_pc_plus4;
    assign o_valid       = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, a HOLD/RUN start-up FSM, the
// next-PC mux, the misaligned-redirect flag and the accepted-fetch counter.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [WORD_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target,
    input  logic              jump,
    input  logic [JIDX_W-1:0] jump_index,
    input  logic [WORD_W-1:0] imem_instruction,
    output logic [WORD_W-1:0] imem_address,
    output logic [WORD_W-1:0] ifid_instruction,
    output logic [WORD_W-1:0] ifid_pc_plus4,
    output logic              ifid_valid,
    output logic              misaligned,
    output logic [WORD_W-1:0] fetch_count
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] w_pc_next;
    logic [WORD_W-1:0] w_pc_plus4;
    logic              r_misaligned;
    logic [WORD_W-1:0] r_fetch_count;
    logic              w_run;
    logic              w_redirect;
    logic              w_bubble;
    logic              w_capture;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_run      = (r_state == RUN);
    assign w_redirect = w_run && (branch_taken || jump);
    assign w_bubble   = !w_run || w_redirect || flush;
    assign w_capture  = w_run && !w_redirect && !flush && !stall;

    // HOLD lasts exactly one cycle after reset; RUN is absorbing.
    always_comb begin
        w_state_next = r_state;
        if (r_state == HOLD) begin
            w_state_next = RUN;
        end
    end

    always_comb begin
        w_pc_next = w_pc_plus4;
        if (!w_run) begin
            w_pc_next = r_pc;
        end else if (branch_taken) begin
            w_pc_next = {branch_target[WORD_W-1:2], 2'b00};
        end else if (jump) begin
            w_pc_next = {w_pc_plus4[WORD_W-1:WORD_W-4], jump_index, 2'b00};
        end else if (stall) begin
            w_pc_next = r_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= HOLD;
            r_pc          <= RESET_PC;
            r_misaligned  <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            // Only branch targets can be misaligned; jump targets are built word-aligned.
            if (w_run && branch_taken && (branch_target[1:0] != 2'b00)) begin
                r_misaligned <= 1'b1;
            end
            if (w_capture) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    ifid_register #(
        .NOP_WORD(NOP_WORD)
    ) u_ifid (
        .clk           (clk),
        .i_reset       (reset),
        .i_load        (w_run),
        .i_bubble      (w_bubble),
        .i_hold        (stall),
        .i_instruction (imem_instruction),
        .i_pc_plus4    (w_pc_plus4),
        .o_instruction (ifid_instruction),
        .o_pc_plus4    (ifid_pc_plus4),
        .o_valid       (ifid_valid)
    );

    assign imem_address = r_pc;
    assign misaligned   = r_misaligned;
    assign fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational instruction-memory model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] imem_instruction;
    logic [31:0] imem_address;
    logic [31:0] ifid_instruction;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic        misaligned;
    logic [31:0] fetch_count;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC(32'h0000_0028),
        .NOP_WORD(32'h0000_0000)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .flush            (flush),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .jump             (jump),
        .jump_index       (jump_index),
        .imem_instruction (imem_instruction),
        .imem_address     (imem_address),
        .ifid_instruction (ifid_instruction),
        .ifid_pc_plus4    (ifid_pc_plus4),
        .ifid_valid       (ifid_valid),
        .misaligned       (misaligned),
        .fetch_count      (fetch_count)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0028) return 32'h0149_4824;
        return {a[15:0], ~a[15:0]};
    endfunction

    assign imem_instruction = mem_word(imem_address);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        branch_taken = 1'b0; branch_target = '0; jump = 1'b0; jump_index = '0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_addr"},  imem_address, 32'h28);
        check({tag, "_instr"}, ifid_instruction, 32'h0);
        check({tag, "_pc4"},   ifid_pc_plus4, 32'h0);
        check({tag, "_valid"}, {31'b0, ifid_valid}, 32'd0);
        check({tag, "_mis"},   {31'b0, misaligned}, 32'd0);
        check({tag, "_cnt"},   fetch_count, 32'd0);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick(); tick();
        check_reset_values("rst");

        reset = 1'b0;
        check("hold_addr", imem_address, 32'h28);
        tick();
        check("run1_addr", imem_address, 32'h28);
        check("run1_valid", {31'b0, ifid_valid}, 32'd0);
        tick();
        check("first_instr", ifid_instruction, 32'h0149_4824);
        check("first_pc4", ifid_pc_plus4, 32'h2C);
        check("first_valid", {31'b0, ifid_valid}, 32'd1);
        check("first_cnt", fetch_count, 32'd1);
        check("seq_addr2c", imem_address, 32'h2C);
        tick();
        check("seq_addr30", imem_address, 32'h30);
        check("seq_cnt2", fetch_count, 32'd2);

        // stall two cycles at PC 0x30
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_addr", imem_address, 32'h30);
            check("stall_instr", ifid_instruction, mem_word(32'h2C));
            check("stall_pc4", ifid_pc_plus4, 32'h30);
            check("stall_cnt", fetch_count, 32'd2);
        end
        stall = 1'b0;
        tick();
        check("seq_addr34", imem_address, 32'h34);
        check("seq_instr30", ifid_instruction, mem_word(32'h30));
        tick();
        check("seq_addr38", imem_address, 32'h38);
        check("seq_cnt4", fetch_count, 32'd4);

        // branch overrides stall
        branch_taken = 1'b1; branch_target = 32'h78; stall = 1'b1;
        tick();
        check("br_addr", imem_address, 32'h78);
        check("br_valid", {31'b0, ifid_valid}, 32'd0);
        check("br_instr", ifid_instruction, 32'h0);
        check("br_cnt", fetch_count, 32'd4);
        idle();
        tick();
        check("br_tgt_instr", ifid_instruction, mem_word(32'h78));
        check("br_tgt_pc4", ifid_pc_plus4, 32'h7C);
        check("br_tgt_valid", {31'b0, ifid_valid}, 32'd1);
        check("br_cnt5", fetch_count, 32'd5);
        check("br_addr7c", imem_address, 32'h7C);

        // jump from 0x7C: {0x80[31:28], 0x10, 00} = 0x40
        jump = 1'b1; jump_index = 26'h000_0010;
        tick();
        check("jmp_addr", imem_address, 32'h40);
        check("jmp_valid", {31'b0, ifid_valid}, 32'd0);
        idle();
        tick();
        check("jmp_instr", ifid_instruction, mem_word(32'h40));
        check("jmp_cnt", fetch_count, 32'd6);

        // branch and jump together: branch wins
        branch_taken = 1'b1; branch_target = 32'h100;
        jump = 1'b1; jump_index = 26'h000_0010;
        tick();
        check("brjmp_addr", imem_address, 32'h100);
        idle();
        tick();
        check("brjmp_instr", ifid_instruction, mem_word(32'h100));
        check("brjmp_cnt", fetch_count, 32'd7);
        check("brjmp_addr104", imem_address, 32'h104);

        // flush with stall: bubble in IF/ID, PC holds
        flush = 1'b1; stall = 1'b1;
        tick();
        check("flush_addr", imem_address, 32'h104);
        check("flush_valid", {31'b0, ifid_valid}, 32'd0);
        check("flush_cnt", fetch_count, 32'd7);
        idle();
        tick();
        check("flush_next_instr", ifid_instruction, mem_word(32'h104));
        check("flush_next_cnt", fetch_count, 32'd8);

        // misaligned branch target
        branch_taken = 1'b1; branch_target = 32'h7A;
        tick();
        check("mis_addr", imem_address, 32'h78);
        check("mis_flag", {31'b0, misaligned}, 32'd1);
        idle();
        tick();
        check("mis_sticky", {31'b0, misaligned}, 32'd1);
        check("mis_cnt", fetch_count, 32'd9);

        // PC wrap at 2^32
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick();
        check("wrap_addr_top", imem_address, 32'hFFFF_FFFC);
        idle();
        tick();
        check("wrap_addr0", imem_address, 32'h0);
        check("wrap_pc4", ifid_pc_plus4, 32'h0);
        check("wrap_instr", ifid_instruction, mem_word(32'hFFFF_FFFC));
        check("wrap_cnt", fetch_count, 32'd10);
        check("wrap_mis", {31'b0, misaligned}, 32'd1);

        // reset mid-stream overrides everything
        reset = 1'b1; branch_taken = 1'b1; branch_target = 32'h200; stall = 1'b1;
        tick();
        check_reset_values("rst2");
        idle();
        tick();
        check("rst2_hold_addr", imem_address, 32'h28);
        check("rst2_hold_valid", {31'b0, ifid_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
